// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: valid/ready handshake in front of a DEPTH-entry circular buffer.
// Flush empties the stage to a bubble; hold freezes the output side only.
module pipe_stage_elastic #(
  parameter int unsigned      WIDTH     = 64,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RST_VALUE = '0,
  parameter int unsigned      CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0]  LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DepthC  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // in_ready looks only at registered count, so a full stage never opens on a same-cycle pop.
  always_comb begin
    in_ready  = (count_q < DepthC);
    out_valid = (count_q != '0) && !hold;
    out_data  = out_valid ? mem_q[rd_ptr_q] : RST_VALUE;
    occupancy = count_q;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; an entry is only visible once counted.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem_q[wr_ptr_q] <= in_data;
  end

  a_stalled_offer_stable : assert property (@(posedge clk) disable iff (rst)
      (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_data)))
    else $warning("stalled offer on in_valid/in_data was withdrawn or changed");

  a_count_bounded : assert property (@(posedge clk) disable iff (rst) count_q <= DepthC)
    else $error("occupancy above DEPTH");

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: three instances (DEPTH 2, 1, 3) checked every cycle against
// an unbounded reference FIFO; outputs are sampled on the falling edge.
module tb_pipe_stage_elastic;

  localparam int unsigned     NI = 3;
  localparam int unsigned     MW = 1024;
  localparam int unsigned     DEP  [NI] = '{2, 1, 3};
  localparam logic [63:0]     RSTV [NI] = '{64'h13, 64'h21, 64'h5a5a};

  logic        clk = 1'b0;
  logic        rst;
  logic        flush     [NI];
  logic        hold      [NI];
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [63:0] in_data   [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [63:0] out_data  [NI];
  logic [3:0]  occ       [NI];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: expected payloads in order of acceptance, per instance.
  logic [63:0] mdl [NI][MW];
  int          head [NI];
  int          tail [NI];
  bit          model_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned CW = $clog2(DEP[g] + 1);
    logic [CW-1:0] occ_w;
    assign occ[g] = 4'(occ_w);
    pipe_stage_elastic #(
      .WIDTH    (64),
      .DEPTH    (DEP[g]),
      .RST_VALUE(RSTV[g])
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush[g]),
      .hold     (hold[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .occupancy(occ_w)
    );
  end

  task automatic chk(input string name, input int inst, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  // Monitor: compare the presented outputs, then apply the coming edge to the model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      automatic int          size   = tail[i] - head[i];
      automatic logic        exp_ov = (size != 0) && !hold[i];
      automatic logic        exp_ir = (size < int'(DEP[i]));
      automatic logic [63:0] exp_od = exp_ov ? mdl[i][head[i] % MW] : RSTV[i];
      if (model_valid) begin
        chk("out_valid", i, 64'(out_valid[i]), 64'(exp_ov));
        chk("out_data", i, out_data[i], exp_od);
        chk("in_ready", i, 64'(in_ready[i]), 64'(exp_ir));
        chk("occupancy", i, 64'(occ[i]), 64'(size));
      end
      if (rst || flush[i]) begin
        head[i] = tail[i];
      end else begin
        if (exp_ov && out_ready[i]) head[i]++;
        if (in_valid[i] && exp_ir) begin
          mdl[i][tail[i] % MW] = in_data[i];
          tail[i]++;
        end
      end
    end
    if (rst) model_valid = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one payload and keep it stable until taken; bounded wait.
  task automatic send(input int i, input logic [63:0] d);
    bit acc = 1'b0;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    for (int k = 0; k < 50; k++) begin
      acc = in_ready[i];
      step();
      if (acc) break;
    end
    in_valid[i] = 1'b0;
    chk("send_accepted", i, 64'(acc), 64'd1);
  endtask

  initial begin
    int  t0;
    bit  acc;
    for (int i = 0; i < NI; i++) begin
      flush[i] = 0; hold[i] = 0; in_valid[i] = 0; out_ready[i] = 0;
      in_data[i] = '0; head[i] = 0; tail[i] = 0;
    end
    // Reset held two cycles while instance 0 offers data.
    rst = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = 64'hdead;
    step(); step();
    rst = 1'b0;
    in_valid[0] = 1'b0;
    step();

    // Fill and backpressure.
    send(0, 64'ha);
    send(0, 64'hb);
    step();
    out_ready[0] = 1'b1;
    step(); step(); step();

    // Streaming: back-to-back on DEPTH=2, every other cycle on DEPTH=1.
    t0 = cyc;
    for (int v = 1; v <= 10; v++) send(0, 64'(v));
    chk("stream_d2_cycles", 0, 64'(cyc - t0), 64'd10);
    step(); step();
    out_ready[1] = 1'b1;
    t0 = cyc;
    for (int v = 1; v <= 10; v++) send(1, 64'(v));
    chk("stream_d1_cycles", 1, 64'(cyc - t0), 64'd19);
    step(); step();

    // Flush a full DEPTH=3 stage while a push is offered.
    send(2, 64'h31); send(2, 64'h32); send(2, 64'h33);
    flush[2] = 1'b1;
    in_valid[2] = 1'b1;
    in_data[2]  = 64'h55;
    step();
    flush[2] = 1'b0;
    in_valid[2] = 1'b0;
    out_ready[2] = 1'b1;
    step(); step(); step();

    // Hold: one entry present, push another while output frozen.
    out_ready[0] = 1'b0;
    send(0, 64'h7);
    hold[0] = 1'b1;
    out_ready[0] = 1'b1;
    send(0, 64'h8);
    step(); step();
    hold[0] = 1'b0;
    step(); step(); step();

    // Random traffic across wrap-around on DEPTH=3.
    acc = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!in_valid[2] || acc) begin
        in_valid[2] = 1'($urandom % 2);
        in_data[2]  = {$urandom, $urandom};
      end
      out_ready[2] = 1'($urandom % 2);
      hold[2]      = ($urandom % 8) == 0;
      flush[2]     = ($urandom % 40) == 0;
      acc = in_valid[2] && in_ready[2];
      step();
    end
    in_valid[2] = 1'b0; hold[2] = 1'b0; flush[2] = 1'b0; out_ready[2] = 1'b1;
    for (int c = 0; c < 6; c++) step();
    for (int i = 0; i < NI; i++) chk("drained", i, 64'(occ[i]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed stall/flush pipeline registers between core stages (IF/ID, ID/EX, EX/Mem, Mem/Wb).
- Replaces the global stall vector with a local valid/ready handshake and a DEPTH-entry skid FIFO.
- Keeps the flush-to-bubble behaviour and the per-instance reset/bubble value, such as a NOP for IF/ID.
- Stages can stall independently, so a Dcache or Icache miss no longer freezes the whole pipe.

Parameters:
- WIDTH, 64, payload width in bits; minimum 1.
- DEPTH, 2, number of buffered entries; minimum 1, need not be a power of two.
- RST_VALUE, {WIDTH{1'b0}}, value driven on out_data whenever the stage holds no valid entry (bubble value).
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  discard all buffered entries this cycle.
- hold  in  1  freeze the output side: no pop, out_valid forced 0.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  stage can accept an entry.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry available downstream.
- out_ready  in  1  downstream accepts the head entry.
- out_data  out  WIDTH  head entry payload, or RST_VALUE when out_valid=0.
- occupancy  out  CNT_W  number of valid entries currently buffered.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clock edge):
  - count, read pointer and write pointer go to 0.
  - out_valid=0, out_data=RST_VALUE, occupancy=0, in_ready=1 from the next cycle.
  - rst has priority over flush, push and pop.
- Storage: circular buffer of DEPTH entries.
  - Pointers increment and wrap from DEPTH-1 to 0; no power-of-two masking.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count < DEPTH).
  - It depends only on registered state, with no combinational path from out_ready.
  - When full, a same-cycle pop does not open in_ready.
- out_valid = (count != 0) & ~hold.
- out_data = buffer[rd_ptr] when out_valid, else RST_VALUE.
  - Driven combinationally from registered state and hold only.
- Count update: count_next = count + push - pop.
  - Push and pop in the same cycle leave count unchanged and advance both pointers.
- Latency: an entry pushed at edge N is visible on out_data from cycle N+1 at the earliest.
- Throughput:
  - DEPTH>=2 sustains one transfer per cycle.
  - DEPTH=1 sustains one transfer every 2 cycles, because in_ready is low while full.
- Flush (flush=1, rst=0):
  - Next state is count=0 and both pointers 0.
  - A same-cycle push is discarded.
  - A same-cycle pop is still counted as accepted by downstream, but its removal is moot.
- hold=1:
  - Suppresses pop and drives RST_VALUE on out_data.
  - Pushes continue until full.
  - flush overrides hold.
- Data ordering: strict FIFO; no entry is duplicated or reordered across wrap-around.
- occupancy mirrors the registered count.
- in_data is sampled only on push; buffer contents are unspecified when not valid and never observable.
- Protocol checks (simulation-only assertions):
  - Warn if in_valid drops or in_data changes while in_valid=1 and in_ready=0.
  - Count never exceeds DEPTH.

Test Plan:
- Reset: DEPTH=2, RST_VALUE=64'h13, hold rst for 2 cycles with in_valid=1 → out_valid=0, out_data=64'h13, occupancy=0, in_ready=1 the cycle after rst drops.
- Fill and backpressure: DEPTH=2, out_ready=0, push 0xA then 0xB → occupancy 1 then 2, and in_ready=0. Then out_ready=1 → out_data 0xA then 0xB in consecutive cycles, and in_ready=1 after the first pop.
- Streaming: DEPTH=2, in_valid=out_ready=1 for 10 cycles with data 1..10 → out_data sequence 1..10, one per cycle, no gaps after the first, occupancy constant at 1. With DEPTH=1 the same stimulus → transfers every other cycle.
- Flush: DEPTH=3 holding 3 entries, assert flush together with in_valid=1 and data 0x55 → next cycle occupancy=0, out_valid=0, out_data=RST_VALUE, and 0x55 never appears at the output.
- Hold: DEPTH=2 holding 1 entry 0x7, hold=1 for 3 cycles with out_ready=1 and one push of 0x8 → out_valid=0 throughout and occupancy goes to 2. On hold release → 0x7 then 0x8.
- Wrap-around: DEPTH=3, random in_valid/out_ready over 200 cycles against a scoreboard → in-order output, no loss, occupancy within 0..3.
